alu_arbiter: RTL and testbench

//   Shares one ALU instance between NREQ requesters using round-robin arbitration.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_arbiter_rr_picker.sv | 40 ++++
 rtl/alu_arbiter.sv | 111 +++++++++++
 tb/tb_alu_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, arbiter state encoding and
// the combinational ALU function evaluated once for the granted requester.
package alu_pkg;

  localparam logic [3:0] ALU_OP_AND = 4'b0000;
  localparam logic [3:0] ALU_OP_OR  = 4'b0001;
  localparam logic [3:0] ALU_OP_ADD = 4'b0010;
  localparam logic [3:0] ALU_OP_SUB = 4'b0110;
  localparam logic [3:0] ALU_OP_SLT = 4'b0111;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_e;

  // Unlisted op codes produce 0 rather than trapping; SLT compares unsigned.
  function automatic logic [31:0] alu_eval(input logic [3:0]  op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      ALU_OP_AND: return a & b;
      ALU_OP_OR:  return a | b;
      ALU_OP_ADD: return a + b;
      ALU_OP_SUB: return a - b;
      ALU_OP_SLT: return {31'b0, a < b};
      default:    return 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Round-robin picker: one-hot grant to the first set req bit at or after ptr,
// wrapping back to bit 0.
module rr_picker #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant
);

  logic [N-1:0] upper;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    upper = '0;
    grant = '0;
    for (int i = 0; i < N; i++) begin
      upper[i] = req[i] && (i >= int'(ptr));
    end
    // Scan downward so the lowest eligible index is the last one written.
    if (upper != '0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (upper[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between NREQ requesters with a one-entry
// registered result. Optional counters are built when ALU_ARB_PERF_EN is defined.
module alu_arbiter #(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*4-1:0] req_op,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [31:0]       rsp_result,
  output logic              rsp_zero
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [NREQ*32-1:0] perf_grant,
  output logic [31:0]       perf_stall
`endif
);

  import alu_pkg::*;

  localparam int IDW = $clog2(NREQ);

  arb_state_e      state;
  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] pick;
  logic            rsp_fire;
  logic            can_accept;
  logic            accept;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  ptr_next;
  logic [31:0]     a_sel;
  logic [31:0]     b_sel;
  logic [3:0]      op_sel;
  logic [31:0]     alu_out;

  rr_picker #(.N(NREQ), .IDW(IDW)) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick)
  );

  // rsp_valid is one-hot on the owner, so this only sees the owner's ready.
  assign rsp_fire   = |(rsp_valid & rsp_ready);
  assign can_accept = (state == ARB_EMPTY) || rsp_fire;
  assign req_ready  = can_accept ? pick : '0;
  assign accept     = |req_ready;

  always_comb begin
    a_sel     = '0;
    b_sel     = '0;
    op_sel    = '0;
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        a_sel     = req_a[32*i +: 32];
        b_sel     = req_b[32*i +: 32];
        op_sel    = req_op[4*i +: 4];
        grant_idx = IDW'(i);
      end
    end
  end

  assign alu_out  = alu_eval(op_sel, a_sel, b_sel);
  assign ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_EMPTY;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rr_ptr     <= '0;
    end else if (accept) begin
      // Accept with a concurrent drain replaces the entry on the same edge.
      state      <= ARB_FULL;
      rsp_valid  <= req_ready;
      rsp_result <= alu_out;
      rsp_zero   <= (alu_out == 32'b0);
      rr_ptr     <= ptr_next;
    end else if (rsp_fire) begin
      state     <= ARB_EMPTY;
      rsp_valid <= '0;
    end
  end

`ifdef ALU_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_grant <= '0;
      perf_stall <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          perf_grant[32*i +: 32] <= perf_grant[32*i +: 32] + 32'd1;
        end
      end
      if ((rsp_valid != '0) && !rsp_fire) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written
// backpressure/reset sequences and a randomized run against a reference model.
module tb_alu_arbiter;

  localparam int NREQ = 2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_BAD = 4'b1111;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_a;
  logic [NREQ*32-1:0]  req_b;
  logic [NREQ*4-1:0]   req_op;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready;
  logic [31:0]         rsp_result;
  logic                rsp_zero;
`ifdef ALU_ARB_PERF_EN
  logic [NREQ*32-1:0]  perf_grant;
  logic [31:0]         perf_stall;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one held entry, its owner, and the round-robin pointer.
  bit          m_full;
  int          m_owner;
  int          m_ptr;
  int          m_last_grant;
  logic [31:0] m_result;

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [3:0]  op0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [3:0]  op1;
    logic [1:0]  exp_ready;
    logic [31:0] exp_result;
    logic        exp_zero;
  } vec_t;

  localparam int NV = 9;
  vec_t vec [NV];

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_grant (perf_grant),
    .perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Requester that would be accepted this cycle, or -1.
  function automatic int model_pick();
    if (m_full && (((rsp_ready >> m_owner) & 1) == 0)) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (((req_valid >> ((m_ptr + k) % NREQ)) & 1) != 0) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    for (int j = 0; j < NREQ; j++) begin
      if (j == i) begin
        req_a[32*j +: 32] = a;
        req_b[32*j +: 32] = b;
        req_op[4*j +: 4]  = op;
      end
    end
  endtask

  task automatic model_reset();
    m_full       = 1'b0;
    m_ptr        = 0;
    m_owner      = 0;
    m_last_grant = -1;
  endtask

  // Advance one clock edge, updating the model from the inputs seen at the edge.
  task automatic tick();
    int g;
    @(posedge clk);
    g = model_pick();
    if (rst) begin
      model_reset();
    end else if (g >= 0) begin
      m_full       = 1'b1;
      m_owner      = g;
      m_ptr        = (g + 1) % NREQ;
      m_result     = alu_ref(4'(req_op >> (4*g)), 32'(req_a >> (32*g)), 32'(req_b >> (32*g)));
      m_last_grant = g;
    end else begin
      m_last_grant = -1;
      if (m_full && (((rsp_ready >> m_owner) & 1) != 0)) m_full = 1'b0;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] exp_valid;
    int g;
    @(negedge clk);
    g = model_pick();
    exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
    exp_valid = m_full ? (NREQ'(1) << m_owner) : '0;
    check({tag, ".req_ready"}, 64'(req_ready), 64'(exp_ready));
    check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(exp_valid));
    if (m_full) begin
      check({tag, ".result"}, 64'(rsp_result), 64'(m_result));
      check({tag, ".zero"}, 64'(rsp_zero), 64'(m_result == 32'd0));
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return OP_AND;
      1:       return OP_OR;
      2:       return OP_ADD;
      3:       return OP_SUB;
      4:       return OP_SLT;
      default: return 4'($urandom);
    endcase
  endfunction

  initial begin
    vec[0] = '{2'b01, 32'd7,    32'd5,          OP_ADD, 32'd0,          32'd0, OP_AND, 2'b01, 32'd12,          1'b0};
    vec[1] = '{2'b11, 32'd1,    32'd1,          OP_AND, 32'd9,          32'd9, OP_SUB, 2'b10, 32'd0,           1'b1};
    vec[2] = '{2'b11, 32'hF0,   32'h0F,         OP_OR,  32'd3,          32'd4, OP_ADD, 2'b01, 32'hFF,          1'b0};
    vec[3] = '{2'b11, 32'd0,    32'd0,          OP_AND, 32'hFFFF_FFFF,  32'd1, OP_ADD, 2'b10, 32'd0,           1'b1};
    vec[4] = '{2'b01, 32'd1,    32'hFFFF_FFFF,  OP_SLT, 32'd0,          32'd0, OP_AND, 2'b01, 32'd1,           1'b0};
    vec[5] = '{2'b01, 32'd5,    32'd6,          OP_BAD, 32'd0,          32'd0, OP_AND, 2'b01, 32'd0,           1'b1};
    vec[6] = '{2'b10, 32'd0,    32'd0,          OP_AND, 32'hFFFF_FFFF,  32'd1, OP_SLT, 2'b10, 32'd0,           1'b1};
    vec[7] = '{2'b01, 32'd3,    32'd5,          OP_SUB, 32'd0,          32'd0, OP_AND, 2'b01, 32'hFFFF_FFFE,   1'b0};
    vec[8] = '{2'b00, 32'd0,    32'd0,          OP_AND, 32'd0,          32'd0, OP_AND, 2'b00, 32'd0,           1'b0};

    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    model_reset();
    m_result = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("reset.rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset.result", 64'(rsp_result), 64'd0);
    check("reset.zero", 64'(rsp_zero), 64'd0);
    check("reset.req_ready", 64'(req_ready), 64'd0);
    tick();

    // Directed vectors, one per cycle, owner always ready.
    rsp_ready = 2'b11;
    for (int k = 0; k <= NV; k++) begin
      if (k < NV) begin
        req_valid = vec[k].valid;
        set_req(0, vec[k].a0, vec[k].b0, vec[k].op0);
        set_req(1, vec[k].a1, vec[k].b1, vec[k].op1);
      end else begin
        req_valid = '0;
      end
      @(negedge clk);
      if (k < NV) check($sformatf("vec%0d.req_ready", k), 64'(req_ready), 64'(vec[k].exp_ready));
      if (k > 0) begin
        check($sformatf("vec%0d.rsp_valid", k - 1), 64'(rsp_valid), 64'(vec[k-1].exp_ready));
        if (vec[k-1].exp_ready != 2'b00) begin
          check($sformatf("vec%0d.result", k - 1), 64'(rsp_result), 64'(vec[k-1].exp_result));
          check($sformatf("vec%0d.zero", k - 1), 64'(rsp_zero), 64'(vec[k-1].exp_zero));
        end
      end
      tick();
    end

    // Backpressure: owner 0 stalls with req1 waiting, then drains with no bubble.
    req_valid = 2'b01;
    set_req(0, 32'd2, 32'd3, OP_ADD);
    @(negedge clk);
    check("bp.grant0", 64'(req_ready), 64'b01);
    tick();
    req_valid = 2'b10;
    set_req(1, 32'd10, 32'd20, OP_ADD);
    for (int c = 0; c < 3; c++) begin
      rsp_ready = (c == 1) ? 2'b10 : 2'b00;
      @(negedge clk);
      check($sformatf("bp.stall%0d.req_ready", c), 64'(req_ready), 64'd0);
      check($sformatf("bp.stall%0d.rsp_valid", c), 64'(rsp_valid), 64'b01);
      check($sformatf("bp.stall%0d.result", c), 64'(rsp_result), 64'd5);
      tick();
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    check("bp.release.req_ready", 64'(req_ready), 64'b10);
    check("bp.release.rsp_valid", 64'(rsp_valid), 64'b01);
    tick();
    req_valid = '0;
    rsp_ready = 2'b11;
    @(negedge clk);
    check("bp.next.rsp_valid", 64'(rsp_valid), 64'b10);
    check("bp.next.result", 64'(rsp_result), 64'd30);
    tick();

    // Reset while FULL: response vanishes at once, pointer returns to 0.
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    set_req(0, 32'd4, 32'd4, OP_SUB);
    @(negedge clk);
    check("rstmid.grant0", 64'(req_ready), 64'b01);
    tick();
    req_valid = '0;
    #2 rst = 1'b1;
    #1 check("rstmid.async_rsp_valid", 64'(rsp_valid), 64'd0);
    model_reset();
    tick();
    #2 rst = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    set_req(0, 32'd1, 32'd2, OP_ADD);
    set_req(1, 32'd3, 32'd4, OP_ADD);
    @(negedge clk);
    check("rstmid.no_stale", 64'(rsp_valid), 64'd0);
    check("rstmid.grant_req0", 64'(req_ready), 64'b01);
    tick();

    // Randomized traffic against the model; operands held while waiting.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || (m_last_grant == i)) begin
          req_valid[i] = ($urandom_range(0, 9) < 7);
          set_req(i, rand_operand(), rand_operand(), rand_op());
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = NREQ'($urandom);
      check_model("rnd");
      tick();
    end

    // Fresh reset, then a short counter scenario.
    req_valid = '0;
    #2 rst = 1'b1;
    model_reset();
    tick();
    #2 rst = 1'b0;
    check_model("post_rst");
    tick();
`ifdef ALU_ARB_PERF_EN
    check("perf.reset_grant", 64'(perf_grant), 64'd0);
    check("perf.reset_stall", 64'(perf_stall), 64'd0);
    req_valid = 2'b10;
    rsp_ready = 2'b11;
    set_req(1, 32'd1, 32'd1, OP_ADD);
    repeat (5) tick();
    req_valid = '0;
    rsp_ready = 2'b00;
    repeat (2) tick();
    rsp_ready = 2'b11;
    tick();
    @(negedge clk);
    check("perf.grant1", 64'(perf_grant[63:32]), 64'd5);
    check("perf.grant0", 64'(perf_grant[31:0]), 64'd0);
    check("perf.stall", 64'(perf_stall), 64'd2);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
